sweep_capture_engine: RTL and testbench

Synthesizable exhaustive-stimulus engine for trojan-detection benchmark runs. Drives a DUT's IN_W-bit input bus through all 2^IN_W vectors in ascending order, waits a programmable settle time, and samples the OUT_W-bit response. Each {vector, response} record is buffered in a FIFO for valid/ready readout and, optionally, folded into a MISR signature. It replaces per-width, hand-written simulation sweeps with one parametrised on-chip/in-bench capture block.

---
 rtl/sweep_capture_engine_pkg.sv | 13 +
 rtl/sweep_capture_engine_if.sv | 25 ++
 rtl/sweep_capture_engine_fifo.sv | 39 +++
 rtl/sweep_capture_engine.sv | 93 +++++++++
 tb/tb_sweep_capture_engine.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/sweep_capture_engine_pkg.sv
// sweep_pkg: shared FSM state type and MISR constants for the sweep capture engine
//   state_t   : IDLE / SETTLE / STALL / DONE
//   MISR_W    : signature width
//   MISR_POLY : feedback polynomial of the signature register
//   misr_step : one signature update with a 16-bit record word
package sweep_pkg;
   typedef enum logic [1:0] {IDLE, SETTLE, STALL, DONE} state_t;
   localparam int MISR_W = 16;
   localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;
   function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] s, input logic [MISR_W-1:0] w);
      return {s[MISR_W-2:0], 1'b0} ^ (s[MISR_W-1] ? MISR_POLY : '0) ^ w;
   endfunction
endpackage

// File: rtl/sweep_capture_engine_if.sv
// sweep_capture_engine_if: control, DUT stimulus/response and record readout bundle
//   start     : begin a sweep (honoured only when idle)
//   busy/done : sweep in progress / one-cycle completion pulse
//   dut_in    : vector applied to the DUT, dut_out : DUT response
//   rec_valid/rec_ready/rec_data : record readout, {vector, response}
//   signature : MISR value (zero when the MISR is not built)
//   master = engine side, slave = consumer/bench side
interface sweep_capture_engine_if
   import sweep_pkg::*;
#(
   parameter int IN_W  = 3,
   parameter int OUT_W = 1
);
   logic                  start;
   logic                  busy;
   logic                  done;
   logic [IN_W-1:0]       dut_in;
   logic [OUT_W-1:0]      dut_out;
   logic                  rec_valid;
   logic                  rec_ready;
   logic [IN_W+OUT_W-1:0] rec_data;
   logic [MISR_W-1:0]     signature;
   modport master (input start, dut_out, rec_ready, output busy, done, dut_in, rec_valid, rec_data, signature);
   modport slave  (output start, dut_out, rec_ready, input busy, done, dut_in, rec_valid, rec_data, signature);
endinterface

// File: rtl/sweep_capture_engine_fifo.sv
// sweep_fifo: record FIFO, synchronous push/pop, async active-low reset
//   CK, reset        : clock, asynchronous active-low reset
//   i_push, i_data   : write a word (caller never pushes when full unless also popping)
//   i_pop            : drop the head word (caller never pops when empty)
//   o_data           : head word, zero when empty
//   o_full, o_empty  : occupancy flags; DEPTH must be a power of two >= 2
module sweep_fifo #(
   parameter int W     = 4,
   parameter int DEPTH = 8
) (
   input  logic         CK,
   input  logic         reset,
   input  logic         i_push,
   input  logic         i_pop,
   input  logic [W-1:0] i_data,
   output logic [W-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] r_mem [DEPTH];
   logic [AW:0]  r_wr, r_rd;
   // extra pointer MSB separates full from empty when the indices match
   assign o_empty = r_wr == r_rd;
   assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign o_data  = o_empty ? '0 : r_mem[r_rd[AW-1:0]];
   always_ff @(posedge CK or negedge reset) begin
      if (!reset) begin
         r_wr <= '0;
         r_rd <= '0;
      end else begin
         if (i_push) r_wr <= r_wr + 1'b1;
         if (i_pop) r_rd <= r_rd + 1'b1;
      end
   end
   always_ff @(posedge CK) begin
      if (i_push) r_mem[r_wr[AW-1:0]] <= i_data;
   end
endmodule

// File: rtl/sweep_capture_engine.sv
// sweep_capture_engine: exhaustive input sweep of a DUT with settle, capture FIFO and optional MISR
//   CK, reset : clock, asynchronous active-low reset
//   bus       : sweep_capture_engine_if.master (start/busy/done, dut_in/dut_out, record readout, signature)
//   Define SWEEP_MISR_EN to build the 16-bit signature register; otherwise signature reads zero.
module sweep_capture_engine
   import sweep_pkg::*;
#(
   parameter int IN_W       = 3,
   parameter int OUT_W      = 1,
   parameter int SETTLE     = 1,
   parameter int FIFO_DEPTH = 8
) (
   input logic                    CK,
   input logic                    reset,
   sweep_capture_engine_if.master bus
);
   localparam int REC_W = IN_W + OUT_W;
   localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CNT_W-1:0] CNT_RLD = CNT_W'(SETTLE - 1);
   state_t           r_state, w_state_nx;
   logic [IN_W-1:0]  r_vec, w_vec_nx;
   logic [CNT_W-1:0] r_cnt, w_cnt_nx;
   logic [REC_W-1:0] w_rec;
   logic             w_push, w_acc, w_pop, w_full, w_empty, w_last;
   assign w_rec  = {r_vec, bus.dut_out};
   assign w_pop  = ~w_empty & bus.rec_ready;
   assign w_push = (r_state == sweep_pkg::SETTLE && r_cnt == '0) || r_state == sweep_pkg::STALL;
   // a full FIFO still accepts when its head leaves on the same edge
   assign w_acc  = w_push & (~w_full | w_pop);
   assign w_last = &r_vec;
   always_ff @(posedge CK or negedge reset) begin
      if (!reset) begin
         r_state <= sweep_pkg::IDLE;
         r_vec   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_vec   <= w_vec_nx;
         r_cnt   <= w_cnt_nx;
      end
   end
   always_comb begin
      w_state_nx = r_state;
      w_vec_nx   = r_vec;
      w_cnt_nx   = r_cnt;
      case (r_state)
         sweep_pkg::IDLE: begin
            if (bus.start) begin
               w_state_nx = sweep_pkg::SETTLE;
               w_vec_nx   = '0;
               w_cnt_nx   = CNT_RLD;
            end
         end
         sweep_pkg::SETTLE, sweep_pkg::STALL: begin
            if (w_acc) begin
               w_state_nx = w_last ? sweep_pkg::DONE : sweep_pkg::SETTLE;
               w_vec_nx   = w_last ? r_vec : r_vec + 1'b1;
               w_cnt_nx   = CNT_RLD;
            end else if (w_push) w_state_nx = sweep_pkg::STALL;
            else w_cnt_nx = r_cnt - 1'b1;
         end
         default: w_state_nx = sweep_pkg::IDLE;
      endcase
   end
   assign bus.busy      = r_state == sweep_pkg::SETTLE || r_state == sweep_pkg::STALL;
   assign bus.done      = r_state == sweep_pkg::DONE;
   assign bus.dut_in    = r_vec;
   assign bus.rec_valid = ~w_empty;
   sweep_fifo #(.W(REC_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .CK      (CK),
      .reset   (reset),
      .i_push  (w_acc),
      .i_pop   (w_pop),
      .i_data  (w_rec),
      .o_data  (bus.rec_data),
      .o_full  (w_full),
      .o_empty (w_empty)
   );
`ifdef SWEEP_MISR_EN
   logic [MISR_W-1:0] r_sig;
   logic [31:0]       w_rec_ext;
   // records wider than the signature contribute only their low bits
   assign w_rec_ext = 32'(w_rec);
   always_ff @(posedge CK or negedge reset) begin
      if (!reset) r_sig <= '0;
      else if (r_state == sweep_pkg::IDLE && bus.start) r_sig <= '0;
      else if (w_acc) r_sig <= misr_step(r_sig, w_rec_ext[MISR_W-1:0]);
   end
   assign bus.signature = r_sig;
`else
   assign bus.signature = '0;
`endif
endmodule

// File: tb/tb_sweep_capture_engine.sv
// tb_sweep_capture_engine: directed scoreboard bench for three engine configurations
module tb_sweep_capture_engine;
   logic CK = 1'b0;
   logic reset = 1'b0;
   always #5 CK = ~CK;
`ifdef SWEEP_MISR_EN
   localparam bit MISR = 1'b1;
`else
   localparam bit MISR = 1'b0;
`endif
   int checks = 0;
   int errors = 0;
   int na = 0, nb = 0, nc = 0;
   logic [31:0] qa[$], qb[$], qc[$];
   logic [31:0] exp_a, exp_b, exp_c;

   sweep_capture_engine_if #(.IN_W(3), .OUT_W(1)) ia();
   sweep_capture_engine_if #(.IN_W(1), .OUT_W(4)) ib();
   sweep_capture_engine_if #(.IN_W(3), .OUT_W(1)) ic();

   sweep_capture_engine #(.IN_W(3), .OUT_W(1), .SETTLE(1), .FIFO_DEPTH(4)) ua (.CK(CK), .reset(reset), .bus(ia));
   sweep_capture_engine #(.IN_W(1), .OUT_W(4), .SETTLE(1), .FIFO_DEPTH(2)) ub (.CK(CK), .reset(reset), .bus(ib));
   sweep_capture_engine #(.IN_W(3), .OUT_W(1), .SETTLE(3), .FIFO_DEPTH(8)) uc (.CK(CK), .reset(reset), .bus(ic));

   assign ia.dut_out = ^ia.dut_in;
   assign ib.dut_out = {ib.dut_in, 3'b010};
   assign ic.dut_out = ^ic.dut_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CK);
      #1;
   endtask

   function automatic logic [31:0] rec3(input int v);
      logic [2:0] x;
      x = 3'(v);
      return 32'({x, ^x});
   endfunction

   function automatic logic [15:0] misr(input logic [15:0] s, input logic [15:0] w);
      return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ w;
   endfunction

   // consumer side: every handshake pops the scoreboard; an empty queue yields an impossible value
   always @(negedge CK) begin
      if (ia.rec_valid && ia.rec_ready) begin
         exp_a = (qa.size() != 0) ? qa.pop_front() : 32'hFFFF_FFFF;
         chk("a_rec", 32'(ia.rec_data), exp_a);
         na++;
      end
      if (ib.rec_valid && ib.rec_ready) begin
         exp_b = (qb.size() != 0) ? qb.pop_front() : 32'hFFFF_FFFF;
         chk("b_rec", 32'(ib.rec_data), exp_b);
         nb++;
      end
      if (ic.rec_valid && ic.rec_ready) begin
         exp_c = (qc.size() != 0) ? qc.pop_front() : 32'hFFFF_FFFF;
         chk("c_rec", 32'(ic.rec_data), exp_c);
         nc++;
      end
   end

   initial begin
      int n;
      int busy_cnt;
      logic [15:0] sig_b;
      ia.start = 1'b0; ia.rec_ready = 1'b0;
      ib.start = 1'b0; ib.rec_ready = 1'b0;
      ic.start = 1'b0; ic.rec_ready = 1'b0;
      #12;
      chk("rst_busy", 32'(ia.busy), 0);
      chk("rst_done", 32'(ia.done), 0);
      chk("rst_dut_in", 32'(ia.dut_in), 0);
      chk("rst_valid", 32'(ia.rec_valid), 0);
      chk("rst_data", 32'(ia.rec_data), 0);
      chk("rst_sig", 32'(ia.signature), 0);
      tick();
      reset = 1'b1;
      tick();

      // basic sweep, plus start pulses while busy and during DONE
      ia.rec_ready = 1'b1;
      for (int v = 0; v < 8; v++) qa.push_back(rec3(v));
      ia.start = 1'b1;
      tick();
      ia.start = 1'b0;
      n = 0;
      busy_cnt = 0;
      while (!ia.done && n < 100) begin
         busy_cnt += int'(ia.busy);
         ia.start = (n == 2);
         tick();
         n++;
      end
      chk("a_done_lat", 32'(n), 8);
      chk("a_busy_cycles", 32'(busy_cnt), 8);
      ia.start = 1'b1;
      tick();
      ia.start = 1'b0;
      chk("a_done_pulse", 32'(ia.done), 0);
      chk("a_start_in_done", 32'(ia.busy), 0);
      repeat (3) tick();
      chk("a_idle_busy", 32'(ia.busy), 0);
      chk("a_hold_ones", 32'(ia.dut_in), 7);
      chk("a_sig", 32'(ia.signature), MISR ? 32'h0077 : 32'h0000);
      chk("a_count", 32'(na), 8);
      chk("a_drained", 32'(qa.size()), 0);
      chk("a_empty", 32'(ia.rec_valid), 0);

      // backpressure: FIFO of four fills, engine stalls on vector 4
      na = 0;
      ia.rec_ready = 1'b0;
      for (int v = 0; v < 8; v++) qa.push_back(rec3(v));
      ia.start = 1'b1;
      tick();
      ia.start = 1'b0;
      repeat (8) tick();
      chk("st_busy", 32'(ia.busy), 1);
      chk("st_dut_in", 32'(ia.dut_in), 4);
      chk("st_valid", 32'(ia.rec_valid), 1);
      chk("st_head", 32'(ia.rec_data), rec3(0));
      tick();
      chk("st_head_stable", 32'(ia.rec_data), rec3(0));
      chk("st_dut_in_held", 32'(ia.dut_in), 4);
      ia.rec_ready = 1'b1;
      n = 9;
      while (!ia.done && n < 100) begin
         tick();
         n++;
      end
      chk("st_done_lat", 32'(n), 13);
      repeat (6) tick();
      chk("st_count", 32'(na), 8);
      chk("st_drained", 32'(qa.size()), 0);
      chk("st_sig", 32'(ia.signature), MISR ? 32'h0077 : 32'h0000);

      // settle of three cycles
      ic.rec_ready = 1'b1;
      for (int v = 0; v < 8; v++) qc.push_back(rec3(v));
      ic.start = 1'b1;
      tick();
      ic.start = 1'b0;
      for (int i = 0; i < 24; i++) begin
         chk("c_hold", 32'(ic.dut_in), 32'(i / 3));
         tick();
      end
      chk("c_done", 32'(ic.done), 1);
      repeat (3) tick();
      chk("c_count", 32'(nc), 8);
      chk("c_drained", 32'(qc.size()), 0);
      chk("c_sig", 32'(ic.signature), MISR ? 32'h0077 : 32'h0000);

      // reset during vector 5 aborts and flushes
      na = 0;
      for (int v = 0; v < 8; v++) qa.push_back(rec3(v));
      ia.start = 1'b1;
      tick();
      ia.start = 1'b0;
      n = 0;
      while (ia.dut_in != 3'd5 && n < 50) begin
         tick();
         n++;
      end
      chk("ab_reach5", 32'(n), 5);
      reset = 1'b0;
      qa.delete();
      #1;
      chk("ab_busy", 32'(ia.busy), 0);
      chk("ab_valid", 32'(ia.rec_valid), 0);
      chk("ab_dut_in", 32'(ia.dut_in), 0);
      chk("ab_sig", 32'(ia.signature), 0);
      chk("ab_recs", 32'(na), 4);
      tick();
      reset = 1'b1;
      tick();
      na = 0;
      for (int v = 0; v < 8; v++) qa.push_back(rec3(v));
      ia.start = 1'b1;
      tick();
      ia.start = 1'b0;
      chk("re_dut_in", 32'(ia.dut_in), 0);
      n = 0;
      while (!ia.done && n < 100) begin
         tick();
         n++;
      end
      chk("re_done_lat", 32'(n), 8);
      repeat (3) tick();
      chk("re_count", 32'(na), 8);
      chk("re_drained", 32'(qa.size()), 0);

      // one-bit input, four-bit output echo
      ib.rec_ready = 1'b1;
      qb.push_back(32'h02);
      qb.push_back(32'h1A);
      sig_b = misr(misr(16'h0000, 16'h0002), 16'h001A);
      ib.start = 1'b1;
      tick();
      ib.start = 1'b0;
      n = 0;
      while (!ib.done && n < 50) begin
         tick();
         n++;
      end
      chk("b_done_lat", 32'(n), 2);
      repeat (3) tick();
      chk("b_count", 32'(nb), 2);
      chk("b_drained", 32'(qb.size()), 0);
      chk("b_sig", 32'(ib.signature), MISR ? 32'(sig_b) : 32'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule
